// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage: opcode-field encodings, ALU op
// codes driven to EX, and the decoded/shaped instruction bundle.
package id_ex_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int OPC_W_DEF = 4;
   localparam int OP_W_DEF  = 3;

   // Opcode field encodings (IR[31:28]); 4'hA..4'hF are unassigned
   localparam logic [3:0] ALU_LI    = 4'h0;
   localparam logic [3:0] ALU_J     = 4'h1;
   localparam logic [3:0] ALU_BGE   = 4'h2;
   localparam logic [3:0] ALU_LW    = 4'h3;
   localparam logic [3:0] ALU_SW    = 4'h4;
   localparam logic [3:0] ALU_ADDU  = 4'h5;
   localparam logic [3:0] ALU_ADDIU = 4'h6;
   localparam logic [3:0] ALU_SLL   = 4'h7;
   localparam logic [3:0] ALU_MUL   = 4'h8;
   localparam logic [3:0] ALU_MULI  = 4'h9;

   // ALU op codes presented to EX
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_BGE = 3'd3;

   // Decoded bundle at the default widths, for fixed-width consumers
   typedef struct packed {
      logic [XLEN_DEF-1:0] ir;
      logic [XLEN_DEF-1:0] d1;
      logic [XLEN_DEF-1:0] d2;
      logic [XLEN_DEF-1:0] d3;
      logic [OP_W_DEF-1:0] op;
      logic                ctl;
      logic                illegal;
   } id_ex_bundle_t;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode decoder: maps the opcode field plus raw operands to
// the shaped operands, ALU op, immediate select and illegal flag.
module id_decode
   import id_ex_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OPC_W = 4,
   parameter int OP_W  = 3
) (
   input  logic [OPC_W-1:0] opc,
   input  logic [XLEN-1:0]  data1,
   input  logic [XLEN-1:0]  data2,
   input  logic [XLEN-1:0]  data3,
   output logic [XLEN-1:0]  d1,
   output logic [XLEN-1:0]  d2,
   output logic [XLEN-1:0]  d3,
   output logic [OP_W-1:0]  op,
   output logic             ctl,
   output logic             illegal
);

   // Opcode table with per-opcode operand shaping; pass-through is the default
   always_comb begin
      d1      = data1;
      d2      = data2;
      d3      = data3;
      op      = OP_W'(OP_ADD);
      ctl     = 1'b0;
      illegal = 1'b0;
      case (opc)
         OPC_W'(ALU_LI), OPC_W'(ALU_J): begin
            d1  = '0;
            d3  = '0;
            ctl = 1'b1;
         end
         OPC_W'(ALU_BGE): begin
            // comparison operands are swapped for the EX comparator
            d1 = data2;
            d2 = data1;
            d3 = '0;
            op = OP_W'(OP_BGE);
         end
         OPC_W'(ALU_LW), OPC_W'(ALU_SW), OPC_W'(ALU_ADDIU): begin
            ctl = 1'b1;
         end
         OPC_W'(ALU_ADDU): begin
            ctl = 1'b0;
         end
         OPC_W'(ALU_SLL): begin
            op  = OP_W'(OP_SLL);
            ctl = 1'b1;
         end
         OPC_W'(ALU_MUL): begin
            op = OP_W'(OP_MUL);
         end
         OPC_W'(ALU_MULI): begin
            op  = OP_W'(OP_MUL);
            ctl = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes on the input side, stores shaped entries in
// a main register (driving EX) backed by a one-entry skid register so that
// in_ready_o can be fully registered without losing instructions.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int OPC_MSB = 31,
   parameter int OPC_W   = 4,
   parameter int OP_W    = 3
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] IR_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic [XLEN-1:0] data3_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] IR_o,
   output logic [XLEN-1:0] data1_o,
   output logic [XLEN-1:0] data2_o,
   output logic [XLEN-1:0] data3_o,
   output logic [OP_W-1:0] op_o,
   output logic            control_o,
   output logic            illegal_o
);

   typedef struct packed {
      logic [XLEN-1:0] ir;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [XLEN-1:0] d3;
      logic [OP_W-1:0] op;
      logic            ctl;
      logic            illegal;
   } entry_t;

   localparam entry_t ENTRY_RST = '{ir: '0, d1: '0, d2: '0, d3: '0,
                                    op: OP_W'(OP_ADD), ctl: 1'b0, illegal: 1'b0};

   entry_t dec_s;
   entry_t main_r;
   entry_t skid_r;
   logic   main_valid_r;
   logic   skid_valid_r;
   logic   in_ready_r;

   logic   accept_s;
   logic   fire_s;
   logic   main_valid_s;
   logic   skid_valid_s;
   logic   load_main_in_s;
   logic   load_main_skid_s;
   logic   load_skid_s;

   assign dec_s.ir = IR_i;

   id_decode #(
      .XLEN  (XLEN),
      .OPC_W (OPC_W),
      .OP_W  (OP_W)
   ) u_decode (
      .opc     (IR_i[OPC_MSB -: OPC_W]),
      .data1   (data1_i),
      .data2   (data2_i),
      .data3   (data3_i),
      .d1      (dec_s.d1),
      .d2      (dec_s.d2),
      .d3      (dec_s.d3),
      .op      (dec_s.op),
      .ctl     (dec_s.ctl),
      .illegal (dec_s.illegal)
   );

   assign accept_s = in_valid_i & in_ready_r;
   assign fire_s   = main_valid_r & out_ready_i;

   // Next-state selection for the two entries; flush overrides accept and fire
   always_comb begin
      main_valid_s     = main_valid_r;
      skid_valid_s     = skid_valid_r;
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      if (flush_i) begin
         main_valid_s = 1'b0;
         skid_valid_s = 1'b0;
      end else if (!main_valid_r || fire_s) begin
         if (skid_valid_r) begin
            // refill main from skid so EX sees the older entry first
            load_main_skid_s = 1'b1;
            main_valid_s     = 1'b1;
            load_skid_s      = accept_s;
            skid_valid_s     = accept_s;
         end else begin
            load_main_in_s = accept_s;
            main_valid_s   = accept_s;
            skid_valid_s   = 1'b0;
         end
      end else begin
         if (accept_s) begin
            load_skid_s  = 1'b1;
            skid_valid_s = 1'b1;
         end else begin
            skid_valid_s = skid_valid_r;
         end
      end
   end

   // Entry registers and registered ready; payload holds when not loaded
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         main_r       <= ENTRY_RST;
         skid_r       <= ENTRY_RST;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         main_valid_r <= main_valid_s;
         skid_valid_r <= skid_valid_s;
         in_ready_r   <= ~skid_valid_s;
         if (load_main_skid_s) begin
            main_r <= skid_r;
         end else if (load_main_in_s) begin
            main_r <= dec_s;
         end
         if (load_skid_s) begin
            skid_r <= dec_s;
         end
      end
   end

   assign in_ready_o  = in_ready_r;
   assign out_valid_o = main_valid_r;
   assign IR_o        = main_r.ir;
   assign data1_o     = main_r.d1;
   assign data2_o     = main_r.d2;
   assign data3_o     = main_r.d3;
   assign op_o        = main_r.op;
   assign control_o   = main_r.ctl;
   assign illegal_o   = main_r.illegal;

endmodule
